// File: rtl/keystream_sequencer.sv
// Frame controller for the three-map keystream mixer: steps the generators, gathers one
// sample per map, drives the mixer, and hands out one keystream byte per pixel.
module keystream_sequencer #(
  parameter int unsigned CNT_W   = 20,
  parameter int unsigned WARMUP  = 16,
  parameter int unsigned MIX_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  output logic             gen_step,
  input  logic             ex1_valid,
  input  logic [22:0]      ex1,
  input  logic             ex2_valid,
  input  logic [22:0]      ex2,
  input  logic             ex3_valid,
  input  logic [22:0]      ex3,
  output logic [22:0]      mix_ex1,
  output logic [22:0]      mix_ex2,
  output logic [22:0]      mix_ex3,
  input  logic [22:0]      mix_v,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [7:0]       ks_byte,
  output logic             busy,
  output logic             done
);

  localparam int unsigned WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int unsigned LAT_W  = $clog2(MIX_LAT + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_COLLECT, S_MIX, S_OUT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   pix_q, pix_d;
  logic [CNT_W:0]     pix_inc;
  logic [WARM_W-1:0]  warm_q, warm_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [2:0]         got_q, got_d;
  logic [22:0]        cap1_q, cap1_d, cap2_q, cap2_d, cap3_q, cap3_d;
  logic [22:0]        mix1_q, mix1_d, mix2_q, mix2_d, mix3_q, mix3_d;
  logic [7:0]         ksb_q, ksb_d;
  logic               ksv_q, ksv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2:0]         vld;
  logic               mix_hi_unused;

  assign vld           = {ex3_valid, ex2_valid, ex1_valid};
  assign mix_hi_unused = ^mix_v[22:8];
  // One extra bit so the last-pixel compare cannot wrap at the maximum frame length
  assign pix_inc       = {1'b0, pix_q} + {{CNT_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      pix_q   <= '0;
      warm_q  <= '0;
      lat_q   <= '0;
      got_q   <= '0;
      cap1_q  <= '0;
      cap2_q  <= '0;
      cap3_q  <= '0;
      mix1_q  <= '0;
      mix2_q  <= '0;
      mix3_q  <= '0;
      ksb_q   <= '0;
      ksv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pix_q   <= pix_d;
      warm_q  <= warm_d;
      lat_q   <= lat_d;
      got_q   <= got_d;
      cap1_q  <= cap1_d;
      cap2_q  <= cap2_d;
      cap3_q  <= cap3_d;
      mix1_q  <= mix1_d;
      mix2_q  <= mix2_d;
      mix3_q  <= mix3_d;
      ksb_q   <= ksb_d;
      ksv_q   <= ksv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pix_d   = pix_q;
    warm_d  = warm_q;
    lat_d   = lat_q;
    got_d   = got_q;
    cap1_d  = cap1_q;
    cap2_d  = cap2_q;
    cap3_d  = cap3_q;
    mix1_d  = mix1_q;
    mix2_d  = mix2_q;
    mix3_d  = mix3_q;
    ksb_d   = ksb_q;
    ksv_d   = ksv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = frame_len;
          pix_d   = '0;
          warm_d  = WARM_W'(WARMUP);
          busy_d  = 1'b1;
          state_d = (frame_len == '0) ? S_DONE : S_STEP;
        end
      end
      S_STEP: begin
        got_d   = '0;
        lat_d   = '0;
        state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (vld[0] && !got_q[0]) cap1_d = ex1;
        if (vld[1] && !got_q[1]) cap2_d = ex2;
        if (vld[2] && !got_q[2]) cap3_d = ex3;
        got_d = got_q | vld;
        // Samples arriving on the completing cycle go straight to the mixer inputs
        if (&got_d) begin
          mix1_d  = cap1_d;
          mix2_d  = cap2_d;
          mix3_d  = cap3_d;
          lat_d   = '0;
          state_d = S_MIX;
        end
      end
      S_MIX: begin
        if (lat_q == LAT_W'(MIX_LAT)) begin
          if (warm_q != '0) begin
            warm_d  = warm_q - WARM_W'(1);
            state_d = S_STEP;
          end else begin
            ksb_d   = mix_v[7:0];
            ksv_d   = 1'b1;
            state_d = S_OUT;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_OUT: begin
        if (ks_ready) begin
          ksv_d   = 1'b0;
          pix_d   = pix_inc[CNT_W-1:0];
          state_d = (pix_inc == {1'b0, len_q}) ? S_DONE : S_STEP;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign gen_step = (state_q == S_STEP);
  assign mix_ex1  = mix1_q;
  assign mix_ex2  = mix2_q;
  assign mix_ex3  = mix3_q;
  assign ks_valid = ksv_q;
  assign ks_byte  = ksb_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
